sequence_generator: RTL and testbench
=====================================

// Module: sequence_generator
// PURPOSE
//   Serial pattern transmitter: accepts a parallel word over a valid/ready load port,
//   shifts it out MSB-first as a one-bit-per-clock serial stream, with optional frame repeats.
//   Transmit-side counterpart of the sequence analyzers; drives their serialInput so that
//   detector stimulus comes from RTL rather than hand-written bit lists.
// PARAMETERS
//   WIDTH  8  maximum frame length in bits; width of load_data
//   LEN_W  4  width of load_len; must hold the value WIDTH
//   REP_W  4  width of load_repeat
// PORTS
//   clk           in   1      rising-edge clock; the only clock in the block
//   reset         in   1      synchronous, active-high reset
//   load_valid    in   1      load request; sampled on rising clk edge
//   load_ready    out  1      1 = block is in IDLE and accepts a load
//   load_data     in   WIDTH  pattern; bit [len-1] is sent first, bit [0] last
//   load_len      in   LEN_W  frame length in bits; 0 or >WIDTH -> WIDTH
//   load_repeat   in   REP_W  extra frame repeats (0 = send the frame once)
//   serialOutput  out  1      serial data; 0 when bit_valid=0
//   bit_valid     out  1      1 = serialOutput carries a frame bit this cycle
//   busy          out  1      1 = transfer in progress (state != IDLE)
//   done          out  1      one-cycle pulse, coincident with the final bit of the transfer
// BEHAVIOUR
//   - All outputs registered. Reset (checked on the clk edge only) -> state IDLE,
//     load_ready=1, serialOutput=0, bit_valid=0, busy=0, done=0.
//   - Reset beats everything: asserted mid-transfer, the transfer aborts on that edge,
//     no done pulse, remaining bits and repeats discarded.
//   - Accept: on an edge with state=IDLE and load_valid=1. Capture data, effective length L,
//     repeat count R. load_valid while busy is ignored. It is not queued.
//   - Latency: the first bit is on serialOutput in the cycle right after the accept edge.
//     Each bit is held exactly one cycle with bit_valid=1.
//   - States:
//       IDLE:   load_ready=1, outputs 0. On accept -> SEND.
//       SEND:   bit index counts L-1 down to 0. After index 0, parity enabled -> PARITY.
//               Otherwise, R>0 -> R-=1 and restart at index L-1 with no gap;
//               R=0 -> IDLE.
//       PARITY: (macro only) one cycle. Then the same repeat/IDLE decision as above.
//   - Total stream = (R+1) x (L [+1 with parity]) consecutive bit_valid cycles.
//   - done=1 only in the cycle carrying the last bit of the last frame.
//   - The next edge returns to IDLE: load_ready=1, busy=0. This gives at least one idle
//     cycle between transfers.
//   - Length rule: L=1 is legal (single-bit frames). load_len=0 or load_len>WIDTH -> L=WIDTH.
//   - Bit counter and repeat counter never wrap; both are compared against 0 before
//     decrementing.
// CONFIGURATION
//   SEQ_GEN_PARITY_EN defined:
//     - After each frame, one extra bit is sent: even parity, the XOR of the L frame bits.
//     - bit_valid=1 during the parity bit.
//     - When it is the final bit of the transfer, done is asserted with it.
//   SEQ_GEN_PARITY_EN undefined:
//     - No PARITY state and no parity logic.
//     - Frames are exactly L bits.
// TESTING
//   1 reset=1 for 2 cycles
//     -> load_ready=1; serialOutput, bit_valid, busy, done all 0.
//   2 data=8'hB4, len=8, rep=0
//     -> serialOutput 1,0,1,1,0,1,0,0 in cycles 1..8; done in cycle 8; load_ready=1 in cycle 9.
//   3 data=8'h05, len=3, rep=2
//     -> 1,0,1,1,0,1,1,0,1 (9 bits, no gaps); done with the 9th bit.
//   4 len=0 and len=12, data=8'hB4
//     -> both behave as len=8 (same stream as test 2).
//     load_valid held high while busy -> ignored, exactly one transfer.
//   5 reset=1 during the 4th bit of test 2
//     -> next cycle: bit_valid=0, busy=0, load_ready=1; no done pulse.
//   6 With SEQ_GEN_PARITY_EN, data=8'hB4 len=8 -> 9 bits, the 9th = 0, done on the 9th.
//     data=8'h07 len=3 rep=1 -> 1,1,1,1,1,1,1,1 (parity 1 after each frame).

Source files
------------

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: loads a word over valid/ready and shifts it out MSB-first with optional repeats.
// Optional even-parity bit after each frame when SEQ_GEN_PARITY_EN is defined.
module sequence_generator #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    input  logic [REP_W-1:0] load_repeat,
    output logic             serialOutput,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    // state  | meaning
    // IDLE   | waiting for a load, load_ready=1, outputs 0
    // SEND   | frame bit r_idx of r_data on serialOutput
    // PARITY | parity bit of the frame just sent (parity build only)
`ifdef SEQ_GEN_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, PARITY = 2'd2} state_t;
    localparam bit PAR_EN = 1'b1;
`else
    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;
    localparam bit PAR_EN = 1'b0;
`endif

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_data;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_idx, w_idx_nxt;
    logic [REP_W-1:0]   r_rep, w_rep_nxt;
    logic               r_bit, r_valid, r_busy, r_done, r_ready;
    logic               w_bit_nxt, w_valid_nxt, w_done_nxt;
    logic               w_accept, w_frame_end;
    logic [LEN_W-1:0]   w_len_eff, w_len_m1;
    logic [WIDTH-1:0]   w_load_shift, w_cur_shift, w_restart_shift;

    // Out-of-range lengths (0 or above WIDTH) fall back to a full-width frame.
    assign w_len_eff       = (load_len == '0 || load_len > LEN_MAX) ? LEN_MAX : load_len;
    assign w_len_m1        = w_len_eff - LEN_ONE;
    assign w_load_shift    = load_data >> w_len_m1;
    assign w_cur_shift     = r_data >> (r_idx - LEN_ONE);
    assign w_restart_shift = r_data >> (r_len - LEN_ONE);

`ifdef SEQ_GEN_PARITY_EN
    logic             r_par;
    logic [WIDTH-1:0] w_mask;
    logic             w_par;
    assign w_mask = ~({WIDTH{1'b1}} << w_len_eff);
    assign w_par  = ^(load_data & w_mask);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_rep_nxt   = r_rep;
        w_bit_nxt   = 1'b0;
        w_valid_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        w_accept    = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            IDLE: begin
                if (load_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SEND;
                    w_idx_nxt   = w_len_m1;
                    w_rep_nxt   = load_repeat;
                    w_bit_nxt   = w_load_shift[0];
                    w_valid_nxt = 1'b1;
                    w_done_nxt  = !PAR_EN && w_len_eff == LEN_ONE && load_repeat == '0;
                end
            end
            SEND: begin
                if (r_idx != '0) begin
                    w_idx_nxt   = r_idx - LEN_ONE;
                    w_bit_nxt   = w_cur_shift[0];
                    w_valid_nxt = 1'b1;
                    w_done_nxt  = !PAR_EN && r_idx == LEN_ONE && r_rep == '0;
                end else begin
`ifdef SEQ_GEN_PARITY_EN
                    w_state_nxt = PARITY;
                    w_bit_nxt   = r_par;
                    w_valid_nxt = 1'b1;
                    w_done_nxt  = r_rep == '0;
`else
                    w_frame_end = 1'b1;
`endif
                end
            end
`ifdef SEQ_GEN_PARITY_EN
            PARITY: w_frame_end = 1'b1;
`endif
            default: w_state_nxt = IDLE;
        endcase

        // Repeat the frame back-to-back, or finish the transfer.
        if (w_frame_end) begin
            if (r_rep != '0) begin
                w_state_nxt = SEND;
                w_rep_nxt   = r_rep - REP_ONE;
                w_idx_nxt   = r_len - LEN_ONE;
                w_bit_nxt   = w_restart_shift[0];
                w_valid_nxt = 1'b1;
                w_done_nxt  = !PAR_EN && r_len == LEN_ONE && r_rep == REP_ONE;
            end else begin
                w_state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_rep   <= '0;
            r_bit   <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
`ifdef SEQ_GEN_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_rep   <= w_rep_nxt;
            r_bit   <= w_bit_nxt;
            r_valid <= w_valid_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            r_ready <= (w_state_nxt == IDLE);
            if (w_accept) begin
                r_data <= load_data;
                r_len  <= w_len_eff;
`ifdef SEQ_GEN_PARITY_EN
                r_par  <= w_par;
`endif
            end
        end
    end

    assign serialOutput = r_bit;
    assign bit_valid    = r_valid;
    assign busy         = r_busy;
    assign done         = r_done;
    assign load_ready   = r_ready;

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator; expected streams are hand-computed for both parity builds.
module tb_sequence_generator;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [7:0] load_data = '0;
    logic [3:0] load_len = '0;
    logic [3:0] load_repeat = '0;
    logic       serialOutput, bit_valid, busy, done;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sequence_generator dut (
        .clk          (clk),
        .reset        (reset),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_data    (load_data),
        .load_len     (load_len),
        .load_repeat  (load_repeat),
        .serialOutput (serialOutput),
        .bit_valid    (bit_valid),
        .busy         (busy),
        .done         (done)
    );

    // Expected streams, first bit in the MSB of the n-bit field.
`ifdef SEQ_GEN_PARITY_EN
    localparam logic [31:0] S_B4 = 32'h168; localparam int N_B4 = 9;   // 10110100 + p0
    localparam logic [31:0] S_05 = 32'hAAA; localparam int N_05 = 12;  // (101 + p0) x3
    localparam logic [31:0] S_07 = 32'hFF;  localparam int N_07 = 8;   // (111 + p1) x2
    localparam logic [31:0] S_L1 = 32'h3F;  localparam int N_L1 = 6;   // (1 + p1) x3
`else
    localparam logic [31:0] S_B4 = 32'hB4;  localparam int N_B4 = 8;
    localparam logic [31:0] S_05 = 32'h16D; localparam int N_05 = 9;
    localparam logic [31:0] S_07 = 32'h3F;  localparam int N_07 = 6;
    localparam logic [31:0] S_L1 = 32'h7;   localparam int N_L1 = 3;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input string tag, input logic [7:0] d, input logic [3:0] l,
                        input logic [3:0] r, input bit hold, input logic [31:0] bits, input int n);
        @(negedge clk);
        load_valid = 1'b1; load_data = d; load_len = l; load_repeat = r;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!hold || i == n - 1) load_valid = 1'b0;
            chk({tag, " bit"},   serialOutput, bits[n-1-i]);
            chk({tag, " valid"}, bit_valid, 1);
            chk({tag, " busy"},  busy, 1);
            chk({tag, " ready"}, load_ready, 0);
            chk({tag, " done"},  done, (i == n - 1));
        end
        @(negedge clk);
        chk({tag, " end valid"}, bit_valid, 0);
        chk({tag, " end busy"},  busy, 0);
        chk({tag, " end ready"}, load_ready, 1);
        chk({tag, " end done"},  done, 0);
        chk({tag, " end sout"},  serialOutput, 0);
        @(negedge clk);
        chk({tag, " idle valid"}, bit_valid, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst ready", load_ready, 1);
        chk("rst sout",  serialOutput, 0);
        chk("rst valid", bit_valid, 0);
        chk("rst busy",  busy, 0);
        chk("rst done",  done, 0);
        reset = 1'b0;

        xfer("b4_len8",  8'hB4, 4'd8,  4'd0, 1'b0, S_B4, N_B4);
        xfer("05_rep2",  8'h05, 4'd3,  4'd2, 1'b0, S_05, N_05);
        xfer("b4_len0",  8'hB4, 4'd0,  4'd0, 1'b0, S_B4, N_B4);
        xfer("b4_len12", 8'hB4, 4'd12, 4'd0, 1'b1, S_B4, N_B4);
        xfer("07_rep1",  8'h07, 4'd3,  4'd1, 1'b0, S_07, N_07);
        xfer("len1_rep2", 8'hFD, 4'd1, 4'd2, 1'b0, S_L1, N_L1);

        // Abort: reset asserted while the 4th bit of a full frame is on the line.
        @(negedge clk);
        load_valid = 1'b1; load_data = 8'hB4; load_len = 4'd8; load_repeat = 4'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            load_valid = 1'b0;
            chk("abort pre bit", serialOutput, S_B4[N_B4-1-i]);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort valid", bit_valid, 0);
        chk("abort busy",  busy, 0);
        chk("abort ready", load_ready, 1);
        chk("abort done",  done, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort quiet valid", bit_valid, 0);
            chk("abort quiet done",  done, 0);
        end

        xfer("after_abort", 8'hB4, 4'd8, 4'd0, 1'b0, S_B4, N_B4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
